// File: rtl/credit_source.sv
// Transmit end of the Avalon-ST credit link: forwards one upstream beat per
// held credit and hands unused credits back to the sink at packet boundaries.
module credit_source #(
  parameter int data_width    = 128,
  parameter int empty_width   = 4,
  parameter int channel_width = 10,
  parameter int credit_width  = 5,
  parameter int idle_cycles   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [channel_width-1:0] avsi_channel,
  input  logic [data_width-1:0]    avsi_data,
  input  logic                     avsi_valid,
  input  logic                     avsi_sop,
  input  logic                     avsi_eop,
  input  logic [empty_width-1:0]   avsi_empty,
  output logic                     avsi_ready,
  input  logic                     update_credit,
  input  logic [credit_width-1:0]  credit,
  output logic                     return_credit,
  output logic [channel_width-1:0] avso_channel,
  output logic [data_width-1:0]    avso_data,
  output logic                     avso_valid,
  output logic                     avso_sop,
  output logic                     avso_eop,
  output logic [empty_width-1:0]   avso_empty,
  input  logic                     return_all,
  output logic                     credit_overflow,
  output logic [credit_width:0]    credit_cnt
);

  localparam int CNT_W = credit_width + 1;
  localparam int SUM_W = credit_width + 2;
  localparam int TMR_W = (idle_cycles > 1) ? $clog2(idle_cycles) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {NORMAL, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     in_pkt_q, in_pkt_d;
  logic                     pend_q, pend_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic                     ret_q, ret_d;
  logic [channel_width-1:0] channel_q;
  logic [data_width-1:0]    data_q;
  logic                     valid_q, sop_q, eop_q;
  logic [empty_width-1:0]   empty_q;

  logic             accept;
  logic             idle_cond;
  logic             idle_fire;
  logic [SUM_W-1:0] sum;

  assign avsi_ready = (state_q == NORMAL) && (cnt_q != '0);
  assign accept     = avsi_valid & avsi_ready;

  always_comb begin
    ret_d     = (state_q == DRAIN) && (cnt_q != '0);
    sum       = SUM_W'(cnt_q) + (update_credit ? SUM_W'(credit) : '0)
              - SUM_W'(accept) - SUM_W'(ret_d);
    cnt_d     = sum[CNT_W-1:0];
    ovf_d     = ovf_q;
    if (sum > SUM_W'(CNT_MAX)) begin
      cnt_d = CNT_MAX;
      ovf_d = 1'b1;
    end

    in_pkt_d = in_pkt_q;
    if (accept) begin
      if (avsi_eop)      in_pkt_d = 1'b0;
      else if (avsi_sop) in_pkt_d = 1'b1;
    end

    // An accepting cycle is never idle, so a beat landing on the last
    // timer cycle restarts the count instead of triggering a return.
    idle_cond = (idle_cycles != 0) && (state_q == NORMAL) && (cnt_q != '0)
              && !in_pkt_q && !accept;
    idle_fire = idle_cond && (timer_q == TMR_W'(idle_cycles - 1));
    timer_d   = timer_q;
    if (accept || (cnt_q == '0) || idle_fire) timer_d = '0;
    else if (idle_cond)                       timer_d = timer_q + 1'b1;

    state_d = state_q;
    case (state_q)
      NORMAL: if (!in_pkt_d && (pend_q || idle_fire)) state_d = DRAIN;
      DRAIN:  if ((cnt_q == '0) && !update_credit)    state_d = NORMAL;
      default: state_d = NORMAL;
    endcase

    pend_d = pend_q;
    if ((state_q == NORMAL) && (state_d == DRAIN)) pend_d = 1'b0;
    if (return_all)                                pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= NORMAL;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      in_pkt_q  <= 1'b0;
      pend_q    <= 1'b0;
      timer_q   <= '0;
      ret_q     <= 1'b0;
      channel_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      empty_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      in_pkt_q <= in_pkt_d;
      pend_q   <= pend_d;
      timer_q  <= timer_d;
      ret_q    <= ret_d;
      valid_q  <= accept;
      if (accept) begin
        channel_q <= avsi_channel;
        data_q    <= avsi_data;
        sop_q     <= avsi_sop;
        eop_q     <= avsi_eop;
        empty_q   <= avsi_eop ? avsi_empty : '0;
      end
    end
  end

  assign return_credit   = ret_q;
  assign avso_channel    = channel_q;
  assign avso_data       = data_q;
  assign avso_valid      = valid_q;
  assign avso_sop        = sop_q;
  assign avso_eop        = eop_q;
  assign avso_empty      = empty_q;
  assign credit_overflow = ovf_q;
  assign credit_cnt      = cnt_q;

endmodule

// File: tb/tb_credit_source.sv
// Directed bench for credit_source: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_credit_source;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   avsi_channel;
  logic [127:0] avsi_data;
  logic         avsi_valid, avsi_sop, avsi_eop;
  logic [3:0]   avsi_empty;
  logic         avsi_ready;
  logic         update_credit;
  logic [4:0]   credit;
  logic         return_credit;
  logic [9:0]   avso_channel;
  logic [127:0] avso_data;
  logic         avso_valid, avso_sop, avso_eop;
  logic [3:0]   avso_empty;
  logic         return_all;
  logic         credit_overflow;
  logic [5:0]   credit_cnt;

  int vectors_applied = 0;
  int miscompares     = 0;

  credit_source dut (
    .clk(clk), .reset(reset),
    .avsi_channel(avsi_channel), .avsi_data(avsi_data), .avsi_valid(avsi_valid),
    .avsi_sop(avsi_sop), .avsi_eop(avsi_eop), .avsi_empty(avsi_empty),
    .avsi_ready(avsi_ready), .update_credit(update_credit), .credit(credit),
    .return_credit(return_credit), .avso_channel(avso_channel), .avso_data(avso_data),
    .avso_valid(avso_valid), .avso_sop(avso_sop), .avso_eop(avso_eop),
    .avso_empty(avso_empty), .return_all(return_all),
    .credit_overflow(credit_overflow), .credit_cnt(credit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    avsi_channel = '0; avsi_data = '0; avsi_valid = 0; avsi_sop = 0;
    avsi_eop = 0; avsi_empty = '0; update_credit = 0; credit = '0; return_all = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic grant(input logic [4:0] n);
    update_credit = 1; credit = n;
    tick();
    update_credit = 0; credit = '0;
  endtask

  task automatic beat(input logic [127:0] d, input logic s, input logic e, input logic [3:0] emp);
    avsi_valid = 1; avsi_data = d; avsi_sop = s; avsi_eop = e; avsi_empty = emp;
    avsi_channel = d[9:0];
  endtask

  initial begin
    int rets, first, ready_seen;
    idle_inputs();
    reset = 1;
    tick();
    check("rst_avso_valid", avso_valid, 0);
    check("rst_avso_data", avso_data, 0);
    check("rst_return", return_credit, 0);
    check("rst_ovf", credit_overflow, 0);
    check("rst_cnt", credit_cnt, 0);
    check("rst_ready", avsi_ready, 0);
    reset = 0;

    // 1: grant 31, 4-beat packet
    tick();
    update_credit = 1; credit = 31;
    #1 check("t1_ready_grant_cycle", avsi_ready, 0);
    tick();
    update_credit = 0; credit = '0;
    check("t1_ready_after_grant", avsi_ready, 1);
    check("t1_cnt31", credit_cnt, 31);
    for (int i = 0; i < 4; i++) begin
      beat(128'd100 + 128'(i), i == 0, i == 3, (i == 3) ? 4'd5 : 4'd3);
      tick();
      check($sformatf("t1_valid%0d", i), avso_valid, 1);
      check($sformatf("t1_data%0d", i), avso_data, 128'd100 + 128'(i));
      check($sformatf("t1_channel%0d", i), avso_channel, 10'd100 + 10'(i));
      check($sformatf("t1_sop%0d", i), avso_sop, (i == 0) ? 1 : 0);
      check($sformatf("t1_eop%0d", i), avso_eop, (i == 3) ? 1 : 0);
      check($sformatf("t1_empty%0d", i), avso_empty, (i == 3) ? 5 : 0);
    end
    avsi_valid = 0;
    tick();
    check("t1_valid_low", avso_valid, 0);
    check("t1_data_hold", avso_data, 103);
    check("t1_cnt27", credit_cnt, 27);

    // 2: two credits, three beats offered
    do_reset();
    grant(2);
    beat(128'd10, 1, 0, 0); tick();
    check("t2_b0_valid", avso_valid, 1);
    beat(128'd11, 0, 0, 0); tick();
    check("t2_b1_data", avso_data, 11);
    check("t2_cnt0", credit_cnt, 0);
    check("t2_ready0", avsi_ready, 0);
    beat(128'd12, 0, 1, 2); tick();
    check("t2_stall_valid", avso_valid, 0);
    update_credit = 1; credit = 1; tick();
    update_credit = 0; credit = '0;
    check("t2_grant_cycle_valid", avso_valid, 0);
    check("t2_ready1", avsi_ready, 1);
    tick();
    avsi_valid = 0;
    check("t2_b2_valid", avso_valid, 1);
    check("t2_b2_data", avso_data, 12);
    check("t2_b2_empty", avso_empty, 2);
    check("t2_cnt_end", credit_cnt, 0);

    // 3: return_all mid-packet, 10 credits, 5 beats
    do_reset();
    grant(10);
    for (int i = 0; i < 5; i++) begin
      beat(128'd200 + 128'(i), i == 0, i == 4, 0);
      return_all = (i == 1);
      tick();
      check($sformatf("t3_valid%0d", i), avso_valid, 1);
      check($sformatf("t3_data%0d", i), avso_data, 128'd200 + 128'(i));
    end
    avsi_valid = 0; return_all = 0;
    check("t3_ready_drain", avsi_ready, 0);
    check("t3_cnt5", credit_cnt, 5);
    rets = 0; first = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (return_credit) begin
        if (first < 0) first = k;
        rets++;
      end
    end
    check("t3_returns", rets, 5);
    check("t3_first_ret", first, 1);
    check("t3_cnt_end", credit_cnt, 0);
    grant(1);
    check("t3_back_normal", avsi_ready, 1);

    // 4: idle timeout with 3 credits
    do_reset();
    grant(3);
    rets = 0; first = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (return_credit) begin
        if (first < 0) first = k;
        rets++;
      end
    end
    check("t4_returns", rets, 3);
    check("t4_first_ret", first, 65);
    check("t4_cnt0", credit_cnt, 0);
    // accept on the last idle cycle restarts the timer
    do_reset();
    grant(3);
    repeat (63) tick();
    beat(128'd55, 1, 1, 1); tick();
    avsi_valid = 0;
    check("t4_late_accept", avso_valid, 1);
    rets = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (return_credit) rets++;
    end
    check("t4_no_return", rets, 0);
    check("t4_cnt2", credit_cnt, 2);

    // 5: grant during drain
    do_reset();
    grant(2);
    return_all = 1; tick();
    return_all = 0; tick();
    check("t5_in_drain", avsi_ready, 0);
    check("t5_cnt2", credit_cnt, 2);
    update_credit = 1; credit = 4;
    rets = 0; ready_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      update_credit = 0; credit = '0;
      if (return_credit) rets++;
      if (avsi_ready) ready_seen++;
    end
    check("t5_returns", rets, 6);
    check("t5_ready_low", ready_seen, 0);
    check("t5_cnt0", credit_cnt, 0);

    // 6: overflow, then reset mid-packet
    do_reset();
    update_credit = 1; credit = 31;
    repeat (3) tick();
    update_credit = 0; credit = '0;
    check("t6_cnt_sat", credit_cnt, 63);
    check("t6_ovf", credit_overflow, 1);
    repeat (150) tick();
    check("t6_ovf_sticky", credit_overflow, 1);
    check("t6_drained", credit_cnt, 0);
    grant(5);
    beat(128'hABC, 1, 0, 0); tick();
    check("t6_pkt_valid", avso_valid, 1);
    reset = 1;
    #1;
    check("t6_rst_valid", avso_valid, 0);
    check("t6_rst_data", avso_data, 0);
    check("t6_rst_cnt", credit_cnt, 0);
    check("t6_rst_ovf", credit_overflow, 0);
    check("t6_rst_ready", avsi_ready, 0);
    check("t6_rst_ret", return_credit, 0);
    idle_inputs();
    tick();
    reset = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/credit_source.md
Name: credit_source

Overview:
- Transmit (source) end of the Avalon-ST credit link; pairs with the credit sink that holds the FIFO and issues credits.
- Accepts a ready/valid packet stream from upstream and forwards one beat per credit held.
- Tracks the credit balance granted by the sink and drives upstream ready from it.
- Returns unused credits to the sink on request or after an idle timeout, only at packet boundaries.

Parameters:
data_width, 128, data bus width
empty_width, 4, empty field width
channel_width, 10, channel field width
credit_width, 5, width of the credit grant field; sink FIFO depth is 2**credit_width
idle_cycles, 64, idle cycles before automatic credit return; 0 disables the timer

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
avsi_channel  in  channel_width  upstream channel
avsi_data  in  data_width  upstream data
avsi_valid  in  1  upstream beat valid
avsi_sop  in  1  start of packet
avsi_eop  in  1  end of packet
avsi_empty  in  empty_width  empty symbols, meaningful only with eop
avsi_ready  out  1  upstream ready, combinational from registered state
update_credit  in  1  sink grants credit this cycle
credit  in  credit_width  credits granted when update_credit=1
return_credit  out  1  one credit returned to sink this cycle
avso_channel  out  channel_width  link channel
avso_data  out  data_width  link data
avso_valid  out  1  link beat valid (no backpressure)
avso_sop  out  1  link sop
avso_eop  out  1  link eop
avso_empty  out  empty_width  link empty
return_all  in  1  pulse: return all held credits at next packet boundary
credit_overflow  out  1  sticky error flag, set when the balance would exceed its maximum
credit_cnt  out  credit_width+1  current credit balance (debug)

Behaviour:
- Reset values: all avso_* 0, return_credit 0, credit_overflow 0, credit_cnt 0, state NORMAL, in_packet 0, idle timer 0, pending_return 0.
- Balance: credit_cnt is credit_width+1 bits wide, maximum value 2**(credit_width+1)-1.
- Next balance = cnt + (update_credit ? credit : 0) - accept - return_credit_next. All terms apply in the same cycle.
- If the sum exceeds the maximum, the balance saturates at the maximum and credit_overflow is set. credit_overflow clears only on reset.
- avsi_ready = (state==NORMAL) && (credit_cnt!=0).
- Accept = avsi_valid & avsi_ready.
- A credit granted this cycle makes avsi_ready high only from the next cycle.
- Forwarding latency is 1 cycle:
  - On accept, all avso_* fields register the input beat and avso_valid goes to 1.
  - avso_empty takes avsi_empty only when eop=1; otherwise it is 0.
  - With no accept, avso_valid is 0 and the other avso_* fields hold their values.
- in_packet: set on accept with sop&!eop; cleared on accept with eop. Accept with sop&eop leaves it 0.
- Idle timer:
  - Counts cycles where state==NORMAL, credit_cnt!=0, !in_packet and no accept.
  - Clears on accept or when credit_cnt==0.
  - Has no effect when idle_cycles==0.
- pending_return: set by return_all (in any state); cleared on entry to DRAIN.
- FSM:
  - NORMAL -> DRAIN when !in_packet and either pending_return=1 or idle timer==idle_cycles-1 (idle_cycles!=0). The transition is evaluated after the current cycle's accept; an accept with sop&!eop blocks it.
  - DRAIN: avsi_ready=0. Each cycle with credit_cnt!=0, return_credit<=1 (registered) and the balance is decremented by 1 on the same edge. A grant arriving during DRAIN is added, then drained.
  - DRAIN -> NORMAL on the first cycle where credit_cnt==0 and update_credit==0. return_credit is 0 in that cycle.
- return_all arriving mid-packet: the drain waits for the eop beat, then starts.
- Reset asserted mid-packet or mid-drain: all state clears immediately. The sink is required to be reset together with this block.

Test Plan:
1. Grant update_credit=1, credit=31 once; send a 4-beat packet back-to-back -> avsi_ready high from the cycle after the grant; avso_valid high 4 consecutive cycles, each 1 cycle after its accept; credit_cnt=27.
2. Grant 2 credits, offer 3 beats continuously -> 2 beats accepted; avsi_ready low with credit_cnt=0. Grant 1 more -> 3rd beat accepted the cycle after the grant.
3. Pulse return_all during beat 2 of a 5-beat packet holding 10 credits -> beats 3..5 accepted; DRAIN entered after eop; return_credit high 5 consecutive cycles; credit_cnt=0; back to NORMAL.
4. idle_cycles=64, hold 3 credits with avsi_valid=0 -> after 64 idle cycles, return_credit pulses 3 cycles. An accept at cycle 63 restarts the timer and no return occurs.
5. In DRAIN with 2 credits, grant credit=4 in the first return cycle -> return_credit high 6 cycles total; avsi_ready stays 0 throughout.
6. Grant 31 three times without sending (max 63) -> credit_overflow=1, credit_cnt=63; flag persists until reset. Also assert reset mid-packet -> all outputs 0 on the next cycle.
